// File: rtl/softstop_pkg.sv
// Shared types and default constants for the soft-stop sequencer.
// Optional HOLD dwell is enabled by defining SOFTSTOP_HOLD_EN.
package softstop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        OFF  = 2'd3
    } state_e;

    localparam int unsigned CODE_W_DEF   = 8;
    localparam int unsigned STEP_DIV_DEF = 16;
    localparam int unsigned HOLD_CYC_DEF = 64;

    // Counter width able to hold values 0..n-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/softstop_tick.sv
// Divide-by-DIV prescaler: while en is high, tick is high on every DIV-th cycle.
// clr restarts the count so the first tick lands DIV cycles after clearing.
module softstop_tick
    import softstop_pkg::*;
#(
    parameter int unsigned DIV = STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned   CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // tick does not look at clr, so a caller may derive clr from tick safely.
    always_comb begin
        cnt_d = cnt_q;
        tick  = en && (cnt_q == LAST);
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/softstop_seq.sv
// Soft-stop sequencer: ramps the reference code down to 0, then disables the gate drive.
// Define SOFTSTOP_HOLD_EN to dwell HOLD_CYC cycles at code 0 before turning off.
module softstop_seq
    import softstop_pkg::*;
#(
    parameter int unsigned CODE_W   = CODE_W_DEF,
    parameter int unsigned STEP_DIV = STEP_DIV_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic [CODE_W-1:0] code_in,
    input  logic              run,
    input  logic              stop_req,
    input  logic              fault,
    input  logic              restart,
    output logic [CODE_W-1:0] ramp_code,
    output logic              busy,
    output logic              drv_off,
    output logic              done
);

    state_e            state_q;
    state_e            state_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    logic              done_q;
    logic              done_d;
    logic [1:0]        rst_sync_q;
    logic [1:0]        rst_sync_d;
    logic              core_en;
    logic              state_chg;
    logic              step_tick;
    logic              unused_pins;

    assign unused_pins = ^{CELV, CELG, SUB};

    // Reset asserts asynchronously but the FSM only starts evaluating two edges after release.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign core_en    = rst_sync_q[1];
    assign state_chg  = (state_d != state_q);

    softstop_tick #(
        .DIV (STEP_DIV)
    ) u_step_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state_chg),
        .en   (state_q == RAMP),
        .tick (step_tick)
    );

`ifdef SOFTSTOP_HOLD_EN
    localparam state_e ZERO_NEXT = HOLD;

    logic hold_tick;

    softstop_tick #(
        .DIV (HOLD_CYC)
    ) u_hold_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state_chg),
        .en   (state_q == HOLD),
        .tick (hold_tick)
    );
`else
    localparam state_e      ZERO_NEXT       = OFF;
    localparam int unsigned UNUSED_HOLD_CYC = HOLD_CYC;
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        done_d  = 1'b0;
        if (core_en) begin
            case (state_q)
                IDLE: begin
                    code_d = code_in;
                    if (fault) begin
                        state_d = OFF;
                    end else if (stop_req && run) begin
                        state_d = RAMP;
                    end
                end
                // stop_req is not consulted here: once started the ramp runs to completion.
                RAMP: begin
                    if (fault) begin
                        state_d = OFF;
                    end else if (code_q == '0) begin
                        state_d = ZERO_NEXT;
                    end else if (step_tick) begin
                        code_d = code_q - 1'b1;
                    end
                end
`ifdef SOFTSTOP_HOLD_EN
                HOLD: begin
                    if (fault || hold_tick) begin
                        state_d = OFF;
                    end
                end
`endif
                default: begin
                    if (restart && !fault) begin
                        state_d = IDLE;
                    end
                end
            endcase
            done_d = (state_d == OFF) && (state_q != OFF);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= '0;
            state_q    <= OFF;
            code_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            rst_sync_q <= rst_sync_d;
            state_q    <= state_d;
            code_q     <= code_d;
            done_q     <= done_d;
        end
    end

    // Outputs decode straight from state so reset reaches them without a clock.
    always_comb begin
        ramp_code = '0;
        busy      = 1'b0;
        drv_off   = 1'b0;
        case (state_q)
            IDLE: ramp_code = code_in;
            RAMP: begin
                ramp_code = code_q;
                busy      = 1'b1;
            end
`ifdef SOFTSTOP_HOLD_EN
            HOLD: busy = 1'b1;
`endif
            default: drv_off = 1'b1;
        endcase
    end

    assign done = done_q;

endmodule

// File: doc/softstop_seq.md
SOFTSTOP_SEQ -- requirements
Module: softstop_seq

Interface
REQ-001 SHALL have parameter CODE_W, default 8, meaning width of the ramp reference code.
REQ-002 SHALL have parameter STEP_DIV, default 16, meaning clock cycles per ramp step (range 1..65535).
REQ-003 SHALL have parameter HOLD_CYC, default 64, meaning dwell cycles at code 0 (used only when SOFTSTOP_HOLD_EN is defined).
REQ-004 SHALL have these ports:
- clk  input  1  sole clock; rising edge.
- rstn  input  1  asynchronous, active-low reset.
- CELV  input  1  supply pin; no functional effect.
- CELG  input  1  ground pin; no functional effect.
- SUB  input  1  substrate pin; no functional effect.
- code_in  input  CODE_W  live code from the soft-start ramp.
- run  input  1  converter is running (soft-start complete or in progress).
- stop_req  input  1  level request for a controlled ramp-down.
- fault  input  1  immediate shutdown request.
- restart  input  1  single-cycle pulse that leaves OFF.
- ramp_code  output  CODE_W  descending reference code.
- busy  output  1  ramp-down or hold in progress.
- drv_off  output  1  gate-drive disable.
- done  output  1  single-cycle pulse on entry to OFF.

Function
REQ-005 SHALL implement states IDLE, RAMP, HOLD and OFF.
REQ-006 In IDLE, ramp_code SHALL track code_in every cycle, with busy=0 and drv_off=0.
REQ-007 In IDLE, stop_req=1 with run=1 SHALL register code_in and enter RAMP on the next cycle.
REQ-008 In RAMP, ramp_code SHALL decrement by 1 once every STEP_DIV cycles, and the first decrement SHALL occur STEP_DIV cycles after entry.
REQ-009 When ramp_code reaches 0, the FSM SHALL enter HOLD if SOFTSTOP_HOLD_EN is defined, otherwise OFF.
REQ-010 A captured code of 0 SHALL go to HOLD or OFF on the cycle after capture.
REQ-011 ramp_code SHALL never wrap below 0.
REQ-012 In OFF, the block SHALL drive ramp_code=0, drv_off=1 and busy=0.
REQ-013 done SHALL pulse for exactly 1 cycle on the cycle OFF is entered.
REQ-014 fault=1 in any state except OFF SHALL enter OFF on the next edge, bypassing RAMP and HOLD.
REQ-015 fault SHALL take priority over simultaneous stop_req or restart.
REQ-016 Deassertion of stop_req during RAMP SHALL be ignored, because the ramp is committed.
REQ-017 run=0 in IDLE SHALL block stop_req, leaving the FSM in IDLE.
REQ-018 In OFF, restart=1 with fault=0 SHALL return the FSM to IDLE.
REQ-019 In OFF, restart SHALL be ignored while fault=1.
REQ-020 The step prescaler SHALL clear on every state change.

Reset
REQ-021 rstn=0 SHALL force state=OFF, ramp_code=0, drv_off=1, busy=0 and done=0 immediately, regardless of clk.
REQ-022 Reset assertion during RAMP or HOLD SHALL abort the sequence.
REQ-023 Exit from reset SHALL require restart.
REQ-024 Reset release SHALL be synchronised internally to clk.

Configuration
REQ-025 Macro SOFTSTOP_HOLD_EN defined: HOLD SHALL keep ramp_code=0, busy=1 and drv_off=0 for HOLD_CYC cycles, then enter OFF.
REQ-026 Macro SOFTSTOP_HOLD_EN undefined: the HOLD state and its counter SHALL be absent, and RAMP SHALL go directly to OFF.

Structure
REQ-027 Package softstop_pkg SHALL hold the state enum (IDLE, RAMP, HOLD, OFF) and default constants for CODE_W, STEP_DIV and HOLD_CYC.
REQ-028 Sub-module softstop_tick SHALL implement the STEP_DIV prescaler with a synchronous clear and a 1-cycle tick output.
REQ-029 softstop_tick SHALL be reused for the HOLD counter.

Verification
REQ-030 Normal ramp: CODE_W=8, STEP_DIV=4, code_in=10, run=1, stop_req pulse -> ramp_code reaches 0 after 40 cycles, then done pulses once and drv_off=1.
REQ-031 Fault priority: fault and stop_req asserted in the same cycle while in IDLE -> OFF next cycle, ramp_code=0, done=1 for 1 cycle, RAMP never entered.
REQ-032 Zero start: code_in=0 with stop_req -> OFF, or HOLD when the macro is defined, 2 cycles after stop_req, and no underflow to 255.
REQ-033 Reset mid-ramp: rstn low at ramp_code=5 -> drv_off=1 asynchronously; after release the FSM stays in OFF until restart, then returns to IDLE and tracks code_in.
REQ-034 Hold build: SOFTSTOP_HOLD_EN defined, HOLD_CYC=8 -> busy=1 and drv_off=0 for exactly 8 cycles at code 0, then done pulses.
REQ-035 Restart during fault: restart pulsed in OFF with fault=1 -> FSM stays in OFF; restart after fault=0 -> IDLE.
